// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel strip controller.
//   state_e       : controller state encoding
//   pixel_t       : 24-bit pixel word {r, g, b}
//   latch_cycles  : latch gap in clk cycles from clock rate and microseconds
package neopixel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_ISSUE,
        S_ACK,
        S_DRAIN,
        S_LATCH
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int unsigned IDX_W   = 8;
    localparam int unsigned LATCH_W = 32;

    // ceil(us * clk_hz / 1e6), never less than one cycle.
    function automatic logic [LATCH_W-1:0] latch_cycles(input logic [63:0] clk_hz,
                                                        input logic [63:0] latch_us);
        logic [63:0] n;
        n = (clk_hz * latch_us + 64'd999_999) / 64'd1_000_000;
        if (n == 64'd0) n = 64'd1;
        return n[LATCH_W-1:0];
    endfunction

endpackage

// File: rtl/neopixel_latch_timer.sv
// Loadable down-counter timing the post-frame latch gap.
//   clk, rst_n : clock, async active-low reset
//   start      : load counter with 'load' this cycle
//   load       : gap length in cycles (>= 1)
//   done       : one-cycle pulse exactly 'load' cycles after the start cycle
module neopixel_latch_timer
    import neopixel_pkg::*;
#(
    parameter int unsigned W = LATCH_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (start)         cnt <= load;
        else if (cnt != '0)     cnt <= cnt - 1'b1;
    end

    // Counter parks at zero, so reaching one happens once per load.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/neopixel_strip_ctrl.sv
// NeoPixel frame sequencer: reads NUM_PIXELS words from a pixel buffer,
// hands each to a bit-serial writer with a px_valid/px_busy handshake,
// then holds the line idle for the latch gap.
//   clk, rst_n          : clock, async active-low reset (release synchronised)
//   frame_start         : pulse to send one frame (ignored while busy)
//   frame_busy          : frame in progress, including latch gap
//   frame_done          : pulse at end of latch gap
//   rd_addr/rd_en       : buffer read, rd_data valid one cycle after rd_en
//   rd_data             : {r, g, b}
//   px_valid, px_r/g/b  : load strobe and colour bytes to the writer
//   px_busy             : writer busy
//   err_timeout         : sticky, writer never acknowledged a pixel
// Build option: define NEOPIXEL_AUTO_REFRESH_EN to restart the frame
// automatically after each latch gap.
module neopixel_strip_ctrl
    import neopixel_pkg::*;
#(
    parameter int unsigned NUM_PIXELS  = 8,
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter int unsigned LATCH_US    = 80,
    parameter int unsigned ACK_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [7:0]  rd_addr,
    output logic        rd_en,
    input  logic [23:0] rd_data,
    output logic        px_valid,
    output logic [7:0]  px_r,
    output logic [7:0]  px_g,
    output logic [7:0]  px_b,
    input  logic        px_busy,
    output logic        err_timeout
);

    localparam logic [LATCH_W-1:0] LATCH_CYC = latch_cycles(64'(CLK_HZ), 64'(LATCH_US));
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_PIXELS - 1);
    localparam int unsigned        ACK_W     = $clog2(ACK_TIMEOUT + 1) + 1;
    localparam logic [ACK_W-1:0]   ACK_LIMIT = ACK_W'(ACK_TIMEOUT - 1);

    logic [1:0]       rst_sync;
    logic             run_ok;
    state_e           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [ACK_W-1:0] ack_cnt, ack_cnt_nxt;
    logic             err_nxt;
    pixel_t           px_q, px_nxt;
    logic             tmr_start, tmr_done;

    // Reset release is brought into the clock domain before a frame may start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run_ok = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            ack_cnt     <= '0;
            err_timeout <= 1'b0;
            px_q        <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            ack_cnt     <= ack_cnt_nxt;
            err_timeout <= err_nxt;
            px_q        <= px_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        ack_cnt_nxt = ack_cnt;
        err_nxt     = err_timeout;
        px_nxt      = px_q;
        tmr_start   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (frame_start && run_ok) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_FETCH:  state_nxt = S_RDWAIT;
            S_RDWAIT: begin
                px_nxt    = pixel_t'(rd_data);
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // Timeout window counts from the px_valid cycle itself.
                ack_cnt_nxt = ACK_W'(1);
                state_nxt   = S_ACK;
            end
            S_ACK: begin
                if (px_busy) begin
                    state_nxt = S_DRAIN;
                end else if (ack_cnt >= ACK_LIMIT) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DRAIN;
                end else begin
                    ack_cnt_nxt = ack_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!px_busy) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_LATCH;
                        tmr_start = 1'b1;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_LATCH: begin
                if (tmr_done) begin
`ifdef NEOPIXEL_AUTO_REFRESH_EN
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    neopixel_latch_timer #(.W(LATCH_W)) u_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tmr_start),
        .load  (LATCH_CYC),
        .done  (tmr_done)
    );

    assign frame_busy = (state != S_IDLE);
    assign frame_done = (state == S_LATCH) && tmr_done;
    assign rd_en      = (state == S_FETCH);
    assign rd_addr    = idx;
    assign px_valid   = (state == S_ISSUE);
    assign px_r       = px_q.r;
    assign px_g       = px_q.g;
    assign px_b       = px_q.b;

endmodule

// File: tb/tb_neopixel_strip_ctrl.sv
// Bench for neopixel_strip_ctrl: event-level model of frame timing
// (px_valid three cycles after start or after writer release, latch gap
// after the last release, timeout window from px_valid) checked every cycle.
module tb_neopixel_strip_ctrl;

    localparam int     NP       = 3;
    localparam int     CLK_HZ   = 12_000_000;
    localparam int     LATCH_US = 80;
    localparam int     ACK_TO   = 32;
    localparam longint LAT_RAW  = (longint'(LATCH_US) * CLK_HZ + 999_999) / 1_000_000;
    localparam longint LAT      = (LAT_RAW < 1) ? 1 : LAT_RAW;

    logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, px_busy = 1'b0;
    logic [23:0] rd_data = '0;
    logic        frame_busy, frame_done, rd_en, px_valid, err_timeout;
    logic [7:0]  rd_addr, px_r, px_g, px_b;

    always #5 clk = ~clk;

    neopixel_strip_ctrl #(.NUM_PIXELS(NP), .CLK_HZ(CLK_HZ), .LATCH_US(LATCH_US),
                          .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_busy(frame_busy),
        .frame_done(frame_done), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .px_valid(px_valid), .px_r(px_r), .px_g(px_g), .px_b(px_b), .px_busy(px_busy),
        .err_timeout(err_timeout)
    );

    // Pixel buffer: registered read, garbage when not read.
    logic [23:0] mem [NP];
    always @(posedge clk)
        rd_data <= rd_en ? ((rd_addr < NP) ? mem[rd_addr] : 24'hDEAD00) : 24'($urandom);

    int total = 0, bad = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state
    bit          m_busy = 0, err_m = 0, prev_err = 0;
    int          pix_i = 0, done_cnt = 0, wr_mode = 0;   // 0 fixed 4/96, 1 random, 2 never busy
    longint      next_issue = -1, done_at = -1, drain = 0, rise_at = 0, fall_at = 0;
    longint      last_valid = -1, first_valid = 0, err_rise = -1, last_gap = 0;
    logic [23:0] obs [NP];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", 64'({rd_en, px_valid, frame_busy, frame_done, err_timeout,
                                      rd_addr, px_r, px_g, px_b}), 64'd0);
            m_busy = 0; err_m = 0; next_issue = -1; done_at = -1; pix_i = 0;
            rise_at = 0; fall_at = 0; last_valid = -1; prev_err = 0;
            px_busy = 1'b0;
        end else begin
            if (wr_mode == 2 && last_valid >= 0 && cyc == last_valid + ACK_TO) err_m = 1;
            if (err_timeout && !prev_err) err_rise = cyc;
            prev_err = err_timeout;

            chk("frame_busy", 64'(frame_busy), 64'(m_busy));
            chk("rd_en", 64'(rd_en), 64'(next_issue >= 0 && cyc == next_issue - 2));
            if (rd_en) chk("rd_addr", 64'(rd_addr), 64'(pix_i));
            chk("px_valid", 64'(px_valid), 64'(next_issue >= 0 && cyc == next_issue));
            chk("frame_done", 64'(frame_done), 64'(done_at >= 0 && cyc == done_at));
            chk("err_timeout", 64'(err_timeout), 64'(err_m));

            if (next_issue >= 0 && cyc == next_issue) begin
                chk("px_rgb", 64'({px_r, px_g, px_b}), 64'(mem[pix_i]));
                obs[pix_i] = {px_r, px_g, px_b};
                if (pix_i == 0) first_valid = cyc;
                last_valid = cyc;
                if (wr_mode == 2) begin
                    rise_at = 0; fall_at = 0;
                    drain = cyc + ACK_TO;
                end else begin
                    rise_at = cyc + ((wr_mode == 0) ? 4  : $urandom_range(1, 8));
                    fall_at = rise_at + ((wr_mode == 0) ? 96 : $urandom_range(1, 100));
                    drain   = fall_at;
                end
                next_issue = -1;
                if (pix_i == NP - 1) done_at = drain + LAT;
                else begin
                    next_issue = drain + 3;
                    pix_i++;
                end
            end

            if (done_at >= 0 && cyc == done_at) begin
                done_cnt++;
                last_gap = cyc - drain;
                done_at  = -1;
`ifdef NEOPIXEL_AUTO_REFRESH_EN
                next_issue = cyc + 3;
                pix_i      = 0;
`else
                m_busy = 0;
`endif
            end

            if (frame_start && !m_busy) begin
                m_busy = 1; err_m = 0; pix_i = 0;
                next_issue = cyc + 3;
            end

            px_busy = (cyc >= rise_at && cyc < fall_at);
        end
    end

    task automatic start_frame();
        @(posedge clk); #2 frame_start = 1'b1;
        @(posedge clk); #2 frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (m_busy && n < budget) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("frame_end", 64'(frame_busy), 64'd0);
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        @(negedge clk);
        while (!(rd_en && rd_addr == 8'(a)) && n < 2000) begin @(negedge clk); n++; end
        chk("reach_pixel", 64'(rd_addr), 64'(a));
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NP; i++) mem[i] = 24'($urandom);
    endtask

    initial begin
        int done_before;
        mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
`ifdef NEOPIXEL_AUTO_REFRESH_EN
        begin
            int n = 0;
            wr_mode = 1;
            start_frame();
            while (done_cnt < 3 && n < 20000) begin @(negedge clk); n++; end
            chk("auto_frames", 64'(done_cnt >= 3), 64'd1);
            @(negedge clk);
            chk("auto_busy_held", 64'(frame_busy), 64'd1);
        end
`else
        // Fixed buffer, fixed writer timing.
        wr_mode = 0;
        start_frame();
        wait_idle(4000);
        chk("A_px0", 64'(obs[0]), 64'h00FF0000);
        chk("A_px1", 64'(obs[1]), 64'h0000FF00);
        chk("A_px2", 64'(obs[2]), 64'h000000FF);
        chk("A_latch_gap", 64'(last_gap), 64'd960);
        chk("A_done_cnt", 64'(done_cnt), 64'd1);
        chk("A_err", 64'(err_timeout), 64'd0);

        // Writer never acknowledges.
        wr_mode = 2; rand_mem();
        start_frame();
        wait_idle(4000);
        chk("B_err_set", 64'(err_timeout), 64'd1);
        chk("B_err_lag", 64'(err_rise - first_valid), 64'd32);
        chk("B_done_cnt", 64'(done_cnt), 64'd2);

        // err clears on new frame; second frame_start mid-frame is ignored.
        wr_mode = 1; rand_mem();
        start_frame();
        @(negedge clk);
        chk("C_err_clr", 64'(err_timeout), 64'd0);
        wait_addr(1);
        start_frame();
        wait_idle(4000);
        chk("C_done_cnt", 64'(done_cnt), 64'd3);

        // Reset in the middle of a frame.
        rand_mem();
        done_before = done_cnt;
        start_frame();
        wait_addr(2);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("D_rst_busy", 64'(frame_busy), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("D_no_done", 64'(done_cnt), 64'(done_before));

        // Random frames after reset, starting again at pixel 0.
        for (int f = 0; f < 4; f++) begin
            rand_mem();
            start_frame();
            wait_idle(4000);
        end
        chk("E_done_cnt", 64'(done_cnt), 64'(done_before + 4));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neopixel_strip_ctrl.md
NEOPIXEL_STRIP_CTRL -- requirements
Module: neopixel_strip_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 8, number of pixels per frame (1..256).
REQ-002 Parameter CLK_HZ, default 12_000_000, input clock rate in Hz.
REQ-003 Parameter LATCH_US, default 80, minimum low gap after a frame, in microseconds.
REQ-004 Parameter ACK_TIMEOUT, default 32, clk cycles to wait for writer busy rise.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 frame_start  input  1  one-cycle pulse requesting transmission of one frame.
REQ-008 frame_busy  output  1  high from accepted frame_start until end of latch gap.
REQ-009 frame_done  output  1  one-cycle pulse when the latch gap completes.
REQ-010 rd_addr  output  8  pixel-buffer read address (pixel index).
REQ-011 rd_en  output  1  pixel-buffer read strobe; data valid exactly 1 cycle later.
REQ-012 rd_data  input  24  pixel word {r[23:16], g[15:8], b[7:0]}.
REQ-013 px_valid  output  1  one-cycle load strobe to the bit-serial writer.
REQ-014 px_r, px_g, px_b  output  8 each  colour bytes presented with px_valid.
REQ-015 px_busy  input  1  writer busy; lags px_valid by several cycles.
REQ-016 err_timeout  output  1  sticky flag: writer never raised px_busy.

Function
REQ-017 States: IDLE, FETCH, RDWAIT, ISSUE, ACK, DRAIN, LATCH.
REQ-018 IDLE: frame_start -> FETCH, pixel index <= 0, frame_busy <= 1; frame_start ignored in every other state.
REQ-019 FETCH: rd_en=1 with rd_addr=index for one cycle -> RDWAIT.
REQ-020 RDWAIT: capture rd_data into px_r/g/b registers -> ISSUE.
REQ-021 ISSUE: px_valid=1 for exactly one cycle, px_* stable from this cycle until next ISSUE -> ACK.
REQ-022 ACK: wait for px_busy=1 -> DRAIN; after ACK_TIMEOUT cycles without it, set err_timeout and -> DRAIN.
REQ-023 DRAIN: wait for px_busy=0; then index==NUM_PIXELS-1 -> LATCH, else index+1 and -> FETCH.
REQ-024 LATCH: count LATCH_US*CLK_HZ/1_000_000 cycles (rounded up, minimum 1) -> IDLE, pulse frame_done, frame_busy <= 0.
REQ-025 px_busy already high on entering ACK counts as acknowledge immediately.
REQ-026 NUM_PIXELS=1: single FETCH..DRAIN pass then LATCH.
REQ-027 Index width 8 bits; index never wraps past NUM_PIXELS-1.
REQ-028 err_timeout clears only on reset or on an accepted frame_start.
REQ-029 Latency frame_start to first px_valid: 3 cycles (FETCH, RDWAIT, ISSUE).

Reset
REQ-030 rst_n low: state IDLE, index 0, latch counter 0, all outputs 0, immediately and asynchronously.
REQ-031 Reset mid-frame abandons the frame with no frame_done; next frame restarts at pixel 0.
REQ-032 Reset release synchronised internally (2-flop) before the state machine leaves IDLE.

Configuration
REQ-033 Macro NEOPIXEL_AUTO_REFRESH_EN defined: LATCH completion returns to FETCH with index 0 instead of IDLE, frame_busy stays 1, frame_done still pulses per frame, frame_start only needed once.
REQ-034 Macro undefined: one frame per frame_start exactly as REQ-024.

Structure
REQ-035 Package neopixel_pkg holds the state enum, pixel word typedef (24-bit r/g/b struct), and the latch-cycle constant function.
REQ-036 Sub-module neopixel_latch_timer: loadable down-counter with start input and done pulse, used by LATCH.

Verification
REQ-037 NUM_PIXELS=3, buffer {FF0000,00FF00,0000FF}, writer model busy 4 cycles after valid for 96 cycles -> three px_valid in order with matching r/g/b, then frame_done.
REQ-038 CLK_HZ=12_000_000, LATCH_US=80 -> exactly 960 cycles from last px_busy fall to frame_done.
REQ-039 Writer model never raises busy -> err_timeout set 32 cycles after each px_valid, frame still completes.
REQ-040 frame_start pulsed during pixel 1 -> ignored; only one frame_done.
REQ-041 rst_n low during pixel 2 -> outputs 0 same cycle; new frame_start restarts at rd_addr 0.
REQ-042 NEOPIXEL_AUTO_REFRESH_EN defined, one frame_start -> frame_done pulses repeatedly every frame, frame_busy never drops.
